// File: rtl/rcv_pkg.sv
// Shared types and constants for the UART receive block.
// Optional build macro: RCV_MAJORITY_VOTE_EN (three-point majority sampling).
package rcv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rcv_state_t;

  localparam logic [13:0] MIN_BIT_PERIOD = 14'd8;

  localparam logic [3:0] SIZE_5 = 4'd5;
  localparam logic [3:0] SIZE_7 = 4'd7;
  localparam logic [3:0] SIZE_8 = 4'd8;

  // Unsupported frame sizes fall back to 8 data bits.
  function automatic logic [3:0] norm_size(input logic [3:0] size);
    if (size == SIZE_5 || size == SIZE_7) begin
      return size;
    end
    return SIZE_8;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rcv_timer.sv
// Bit-period counter: strobes when the count reaches the target.
// With RCV_MAJORITY_VOTE_EN, also flags the two cycles before the strobe.
module rcv_timer
  import rcv_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic [13:0] target,
`ifdef RCV_MAJORITY_VOTE_EN
  output logic        vote_window,
`endif
  output logic        sample_strobe
);

  logic [13:0] r_cnt;
  logic        w_strobe;

  assign w_strobe      = (r_cnt == target);
  assign sample_strobe = w_strobe;

`ifdef RCV_MAJORITY_VOTE_EN
  assign vote_window = (r_cnt == target - 14'd2) || (r_cnt == target - 14'd1);
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if (clear || w_strobe) begin
      r_cnt <= 14'd1;
    end else begin
      r_cnt <= r_cnt + 14'd1;
    end
  end

endmodule

// File: rtl/uart_rcv_block.sv
// UART serial receiver: synchroniser, start detect, frame FSM and status flags.
// Optional build macro: RCV_MAJORITY_VOTE_EN (three-point majority sampling).
module uart_rcv_block
  import rcv_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        serial_in,
  input  logic [3:0]  data_size,
  input  logic [13:0] bit_period,
  input  logic        data_read,
  output logic [7:0]  rx_data,
  output logic        data_ready,
  output logic        overrun_error,
  output logic        framing_error
);

  logic [1:0]  r_sync;
  logic        r_prev;
  rcv_state_t  r_state;
  logic [3:0]  r_size;
  logic [13:0] r_bp;
  logic [7:0]  r_shift;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_rx_data;
  logic        r_data_ready;
  logic        r_overrun;
  logic        r_framing;

  logic        w_fall;
  logic        w_clear;
  logic [13:0] w_target;
  logic        w_strobe;
  logic        w_bit;

  assign rx_data       = r_rx_data;
  assign data_ready    = r_data_ready;
  assign overrun_error = r_overrun;
  assign framing_error = r_framing;

  assign w_fall   = r_prev & ~r_sync[1];
  assign w_clear  = (r_state == IDLE);
  assign w_target = (r_state == START) ? {1'b0, r_bp[13:1]} : r_bp;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync <= 2'b11;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], serial_in};
      r_prev <= r_sync[1];
    end
  end

`ifdef RCV_MAJORITY_VOTE_EN
  logic       w_vote_window;
  logic [1:0] r_vote;

  rcv_timer u_timer (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (w_clear),
    .target        (w_target),
    .vote_window   (w_vote_window),
    .sample_strobe (w_strobe)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_vote <= '1;
    end else if (w_vote_window) begin
      r_vote <= {r_vote[0], r_sync[1]};
    end
  end

  assign w_bit = maj3(r_vote[1], r_vote[0], r_sync[1]);
`else
  rcv_timer u_timer (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (w_clear),
    .target        (w_target),
    .sample_strobe (w_strobe)
  );

  assign w_bit = r_sync[1];
`endif

  // Flag updates in the STOP branch come after the data_read clear so a
  // good load in the same cycle as an acknowledge keeps data_ready set.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= IDLE;
      r_size       <= '0;
      r_bp         <= '0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_rx_data    <= '0;
      r_data_ready <= 1'b0;
      r_overrun    <= 1'b0;
      r_framing    <= 1'b0;
    end else begin
      if (data_read) begin
        r_data_ready <= 1'b0;
        r_overrun    <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_fall && (bit_period >= MIN_BIT_PERIOD)) begin
            r_state <= START;
            r_bp    <= bit_period;
            r_size  <= norm_size(data_size);
          end
        end
        START: begin
          if (w_strobe) begin
            if (!w_bit) begin
              r_state   <= DATA;
              r_shift   <= '0;
              r_bit_cnt <= '0;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        DATA: begin
          if (w_strobe) begin
            r_shift   <= {w_bit, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if ((r_bit_cnt + 4'd1) == r_size) begin
              r_state <= STOP;
            end
          end
        end
        STOP: begin
          if (w_strobe) begin
            r_state <= IDLE;
            if (w_bit) begin
              r_rx_data    <= r_shift;
              r_data_ready <= 1'b1;
              r_framing    <= 1'b0;
              if (r_data_ready && !data_read) begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_framing <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rcv_block.md
# uart_rcv_block

- Serial receive front end of the UART peripheral, directly upstream of the APB register slave.
- Synchronises the serial line and detects a start bit.
- Samples 5, 7 or 8 data bits, LSB first, at a programmable bit period, then checks the stop bit.
- Presents the received frame with `data_ready`, `overrun_error` and `framing_error` flags, which the APB slave reads and acknowledges with `data_read`.

## Interface
Parameters: none. Widths are fixed by the APB register map.
- `clk` in 1: system clock. Everything is on the rising edge.
- `n_rst` in 1: asynchronous, active-low reset.
- `serial_in` in 1: asynchronous serial line. It idles high.
- `data_size` in 4: data bits per frame. Valid values are 5, 7 and 8; any other value is treated as 8.
- `bit_period` in 14: clocks per bit. Values below 8 disable the receiver.
- `data_read` in 1: single-cycle acknowledge from the APB slave when it reads the data register.
- `rx_data` out 8: last good frame, MSB-justified. The data occupies `[7:8-size]` and the lower bits are 0.
- `data_ready` out 1: an unread good frame is held in `rx_data`.
- `overrun_error` out 1: a good frame arrived while `data_ready` was still 1.
- `framing_error` out 1: the last completed frame had its stop bit sampled as 0.

## Operation
**Synchroniser and start detect**
- `serial_in` passes through a 2-flop synchroniser; both flops reset to 1.
- A falling edge is detected from the synchronised value and its previous value (high followed by low).

**Configuration latch**
- On start detect, `data_size` and `bit_period` are latched into frame-local registers.
- APB writes made mid-frame do not affect the frame in flight.

**Timer**
- `cnt` loads 1 on state entry and on every sample, and increments every cycle.
- A sample is taken on the edge where `cnt == target`.
- In START, `target = bit_period >> 1`. In DATA and STOP, `target = bit_period`.

**State machine (package enum)**
- IDLE → START: on a falling edge, when the latched `bit_period` is 8 or more. Otherwise stay in IDLE.
- START → DATA: sampled bit is 0. The shift register clears and `bit_cnt` is set to 0.
- START → IDLE: sampled bit is 1 (false start). No flags change.
- DATA: each sample shifts right with the new bit entering at bit 7, and `bit_cnt` increments. When `bit_cnt` reaches the size, go to STOP.
- STOP → IDLE: always, on the stop sample edge.
  - Stop bit 1: `rx_data` is loaded from the shift register, `data_ready` is set and `framing_error` is cleared.
  - Stop bit 0: `framing_error` is set. `rx_data`, `data_ready` and `overrun_error` are unchanged and the frame is discarded.

**Flag rules**
- `data_read` clears `data_ready` and `overrun_error` on the next edge.
- On a good load while `data_ready == 1` and `data_read == 0`: `overrun_error` is set and `rx_data` is overwritten with the new frame.
- Good load and `data_read` in the same cycle: `data_ready` stays 1 and `overrun_error` is not set.
- `data_read` in IDLE with `data_ready == 0`: no effect.

**Reset**
- Asserting `n_rst`, including mid-frame, forces the state to IDLE.
- It also clears the counters and the shift register and zeroes all outputs.
- The line is not re-armed until a new falling edge is seen.

## Timing
- Reset values: `rx_data = 8'h00`, `data_ready = 0`, `overrun_error = 0`, `framing_error = 0`, state IDLE, synchroniser `2'b11`.
- Start detect happens 2 clocks after the line falls, due to the synchroniser.
- Start sample: `bit_period >> 1` clocks after start detect.
- Data bit k is sampled `(bit_period >> 1) + (k+1)·bit_period` clocks after start detect, for k = 0 to size−1.
- Stop sample and output update: `(bit_period >> 1) + (size+1)·bit_period` clocks after start detect.
- Outputs are registered; there is no combinational path from input to output.
- Back-to-back frames: a falling edge arriving on the cycle after the stop sample is detected.

## Configuration
- `RCV_MAJORITY_VOTE_EN` defined: every sample is the majority of the synchronised line at `cnt == target-2`, `target-1` and `target`. This gives noise rejection on each bit.
- Undefined: every sample is the single synchronised value at `cnt == target`.
- Sample edges, state transitions and latency are identical in both builds.

## Structure
- `rcv_pkg` contains:
  - `rcv_state_t` (IDLE, START, DATA, STOP);
  - `MIN_BIT_PERIOD = 14'd8`;
  - the valid sizes `SIZE_5`, `SIZE_7`, `SIZE_8`.
- Sub-module `rcv_timer` is the bit-period counter. It takes `clk`, `n_rst`, `clear`, `target` and returns `sample_strobe`, plus `vote_window` when `RCV_MAJORITY_VOTE_EN` is defined.
- The top level holds the synchroniser, the FSM, the shift register and the flags.

## Test plan
- Good 8-bit frame: `bit_period = 10`, `data_size = 8`, send `0xA5` LSB first with stop bit 1 → `rx_data = 8'hA5`, `data_ready = 1` on the stop sample edge, both errors 0.
- Good 5-bit frame: `data_size = 5`, send bits 0,1,1,0,1 → `rx_data = 8'hB0`.
- Framing error: send `0x3C` with stop bit 0 → `framing_error = 1`, `rx_data` and `data_ready` unchanged. A following good `0x11` → `framing_error = 0`, `rx_data = 8'h11`.
- Overrun: two good frames `0x01` then `0x02` with no `data_read` → `overrun_error = 1`, `rx_data = 8'h02`. A `data_read` pulse clears both flags next cycle.
- False start: `bit_period = 16`, line low for 3 clocks → back to IDLE, no flag change.
- Reset mid-frame: assert `n_rst` during data bit 3 → all outputs 0. A subsequent frame `0x5A` is received correctly.
